// File: rtl/fwd_scoreboard_unit.sv
// Decode-side hazard scoreboard: tracks DEPTH post-decode stages, raises the
// load-use stall and picks the youngest forwarding source for each read port.
module fwd_scoreboard_unit #(
  parameter int  NPORTS     = 2,
  parameter int  DEPTH      = 3,
  parameter int  LOAD_STAGE = 3,
  localparam int SELW       = $clog2(DEPTH + 1)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        advance,
  input  logic                        flush,
  input  logic                        id_valid,
  input  logic                        id_wen,
  input  logic [4:0]                  id_rd,
  input  logic                        id_is_load,
  input  logic [NPORTS-1:0][4:0]      id_src,
  input  logic [NPORTS-1:0]           id_src_used,
  output logic                        stall,
  output logic [NPORTS-1:0][SELW-1:0] fwd_sel,
  output logic [15:0]                 stall_count
);

  logic [DEPTH:1]         valid_q, valid_d;
  logic [DEPTH:1]         wen_q, wen_d;
  logic [DEPTH:1]         load_q, load_d;
  logic [DEPTH:1][4:0]    rd_q, rd_d;
  logic [NPORTS-1:0][4:0] src_q, src_d;
  logic [NPORTS-1:0]      src_used_q, src_used_d;
  logic [15:0]            stall_count_q, stall_count_d;
  logic [DEPTH:1]         producer;
  logic                   load_hit;

  always_comb begin
    producer = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      producer[k] = valid_q[k] & wen_q[k] & (rd_q[k] != '0);
    end
  end

  // Loads in stages 1..LOAD_STAGE-2 cannot have their data ready by the time
  // the decode instruction reaches stage 1, so the consumer must wait.
  always_comb begin
    load_hit = 1'b0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      for (int unsigned s = 1; s + 2 <= LOAD_STAGE; s++) begin
        if (id_src_used[p] && producer[s] && load_q[s] && (rd_q[s] == id_src[p])) begin
          load_hit = 1'b1;
        end
      end
    end
    stall = id_valid & ~flush & load_hit;
  end

  // Scan oldest to youngest so the youngest matching stage is the last write.
  always_comb begin
    fwd_sel = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (valid_q[1] && src_used_q[p]) begin
        for (int unsigned k = DEPTH; k >= 2; k--) begin
          if (producer[k] && (rd_q[k] == src_q[p])) begin
            fwd_sel[p] = SELW'(k);
          end
        end
      end
    end
  end

  always_comb begin
    valid_d       = valid_q;
    wen_d         = wen_q;
    load_d        = load_q;
    rd_d          = rd_q;
    src_d         = src_q;
    src_used_d    = src_used_q;
    stall_count_d = stall_count_q;
    if (advance) begin
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        wen_d[k]   = wen_q[k-1];
        load_d[k]  = load_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      valid_d[1] = id_valid & ~flush & ~stall;
      wen_d[1]   = id_wen;
      load_d[1]  = id_is_load;
      rd_d[1]    = id_rd;
      src_d      = id_src;
      src_used_d = id_src_used;
      if (stall && (stall_count_q != '1)) begin
        stall_count_d = stall_count_q + 16'd1;
      end
    end else if (flush) begin
      valid_d[1] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q       <= '0;
      wen_q         <= '0;
      load_q        <= '0;
      rd_q          <= '0;
      src_q         <= '0;
      src_used_q    <= '0;
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      wen_q         <= wen_d;
      load_q        <= load_d;
      rd_q          <= rd_d;
      src_q         <= src_d;
      src_used_q    <= src_used_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Scoreboard bench for fwd_scoreboard_unit: default, swept and deep-pipeline
// instances driven by directed vectors, checked by a decoupled monitor.
module tb_fwd_scoreboard_unit;

  localparam logic [2:0] CK_ST  = 3'b001;
  localparam logic [2:0] CK_FW  = 3'b010;
  localparam logic [2:0] CK_CN  = 3'b100;
  localparam logic [2:0] CK_ALL = 3'b111;

  logic clk;
  logic rst_n;
  logic t_rst_n;

  // default instance
  logic            m_adv, m_flush, m_valid, m_wen, m_load;
  logic [4:0]      m_rd;
  logic [1:0][4:0] m_src;
  logic [1:0]      m_used;
  logic            m_stall;
  logic [1:0][1:0] m_fwd;
  logic [15:0]     m_cnt;

  // NPORTS=3, DEPTH=5, LOAD_STAGE=4
  logic            s_adv, s_flush, s_valid, s_wen, s_load;
  logic [4:0]      s_rd;
  logic [2:0][4:0] s_src;
  logic [2:0]      s_used;
  logic            s_stall;
  logic [2:0][2:0] s_fwd;
  logic [15:0]     s_cnt;

  // NPORTS=1, DEPTH=7, LOAD_STAGE=7: five bubbles per six cycles to reach saturation
  logic            t_adv, t_flush, t_valid, t_wen, t_load;
  logic [4:0]      t_rd;
  logic [0:0][4:0] t_src;
  logic [0:0]      t_used;
  logic            t_stall;
  logic [0:0][2:0] t_fwd;
  logic [15:0]     t_cnt;

  fwd_scoreboard_unit dut_m (
    .CLK(clk), .nRST(rst_n), .advance(m_adv), .flush(m_flush),
    .id_valid(m_valid), .id_wen(m_wen), .id_rd(m_rd), .id_is_load(m_load),
    .id_src(m_src), .id_src_used(m_used),
    .stall(m_stall), .fwd_sel(m_fwd), .stall_count(m_cnt)
  );

  fwd_scoreboard_unit #(.NPORTS(3), .DEPTH(5), .LOAD_STAGE(4)) dut_s (
    .CLK(clk), .nRST(rst_n), .advance(s_adv), .flush(s_flush),
    .id_valid(s_valid), .id_wen(s_wen), .id_rd(s_rd), .id_is_load(s_load),
    .id_src(s_src), .id_src_used(s_used),
    .stall(s_stall), .fwd_sel(s_fwd), .stall_count(s_cnt)
  );

  fwd_scoreboard_unit #(.NPORTS(1), .DEPTH(7), .LOAD_STAGE(7)) dut_t (
    .CLK(clk), .nRST(t_rst_n), .advance(t_adv), .flush(t_flush),
    .id_valid(t_valid), .id_wen(t_wen), .id_rd(t_rd), .id_is_load(t_load),
    .id_src(t_src), .id_src_used(t_used),
    .stall(t_stall), .fwd_sel(t_fwd), .stall_count(t_cnt)
  );

  always #5 clk = ~clk;

  string       q_nm[$];
  int          q_inst[$];
  logic [2:0]  q_mask[$];
  logic        q_st[$];
  logic [8:0]  q_fw[$];
  logic [15:0] q_cn[$];
  int unsigned n_total;
  int unsigned n_pass;
  event        chk_ev;

  task automatic push_exp(input string nm, input int inst, input logic [2:0] mask,
                          input logic st, input logic [8:0] fw, input logic [15:0] cn);
    q_nm.push_back(nm);
    q_inst.push_back(inst);
    q_mask.push_back(mask);
    q_st.push_back(st);
    q_fw.push_back(fw);
    q_cn.push_back(cn);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m_dec(input logic v, input logic wen, input logic [4:0] rd, input logic ld,
                       input logic [4:0] a, input logic [4:0] b, input logic [1:0] u);
    m_valid = v; m_wen = wen; m_rd = rd; m_load = ld;
    m_src[0] = a; m_src[1] = b; m_used = u;
  endtask

  task automatic s_dec(input logic v, input logic wen, input logic [4:0] rd, input logic ld,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic [2:0] u);
    s_valid = v; s_wen = wen; s_rd = rd; s_load = ld;
    s_src[0] = a; s_src[1] = b; s_src[2] = c; s_used = u;
  endtask

  function automatic logic [15:0] sat_cnt(input int unsigned c);
    int unsigned n;
    n = c - (c + 5) / 6;
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  // monitor: compares every pending expectation at the falling edge, or at once on chk_ev
  initial begin
    string       nm;
    int          inst;
    logic [2:0]  mask;
    logic        st, a_st;
    logic [8:0]  fw, a_fw;
    logic [15:0] cn, a_cn;
    logic        ok;
    forever begin
      @(negedge clk or chk_ev);
      while (q_nm.size() != 0) begin
        nm = q_nm.pop_front(); inst = q_inst.pop_front(); mask = q_mask.pop_front();
        st = q_st.pop_front(); fw = q_fw.pop_front(); cn = q_cn.pop_front();
        case (inst)
          0:       begin a_st = m_stall; a_fw = 9'(m_fwd); a_cn = m_cnt; end
          1:       begin a_st = s_stall; a_fw = 9'(s_fwd); a_cn = s_cnt; end
          default: begin a_st = t_stall; a_fw = 9'(t_fwd); a_cn = t_cnt; end
        endcase
        ok = (!mask[0] || a_st === st) && (!mask[1] || a_fw === fw) && (!mask[2] || a_cn === cn);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got stall=%0b fwd=%0h count=%0h, want stall=%0b fwd=%0h count=%0h (mask %0d)",
                      nm, a_st, a_fw, a_cn, st, fw, cn, mask);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    n_total = 0; n_pass = 0;
    clk = 1'b0; rst_n = 1'b0; t_rst_n = 1'b0;
    m_adv = 1'b1; m_flush = 1'b0; m_dec(1'b1, 1'b1, 5'd8, 1'b1, 5'd8, 5'd8, 2'b11);
    s_adv = 1'b1; s_flush = 1'b0; s_dec(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, '0);
    t_adv = 1'b1; t_flush = 1'b0; t_valid = 1'b1; t_wen = 1'b1; t_rd = 5'd8;
    t_load = 1'b1; t_src[0] = 5'd8; t_used = 1'b1;

    #3;
    push_exp("reset_main", 0, CK_ALL, 1'b0, 9'd0, 16'd0);
    push_exp("reset_sweep", 1, CK_ALL, 1'b0, 9'd0, 16'd0);
    push_exp("reset_deep", 2, CK_ALL, 1'b0, 9'd0, 16'd0);
    -> chk_ev;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU chain: add r5 then two consumers of r5
    m_dec(1'b1, 1'b1, 5'd5, 1'b0, 5'd1, 5'd2, 2'b11);
    push_exp("first_cycle_after_reset", 0, CK_ALL, 1'b0, 9'd0, 16'd0);
    tick;
    m_dec(1'b1, 1'b1, 5'd6, 1'b0, 5'd5, 5'd0, 2'b01);
    push_exp("alu_no_producer", 0, CK_FW, 1'b0, 9'd0, 16'd0);
    tick;
    m_dec(1'b1, 1'b1, 5'd7, 1'b0, 5'd5, 5'd0, 2'b01);
    push_exp("alu_fwd_from_2", 0, CK_ST | CK_FW, 1'b0, 9'b0_0000_0010, 16'd0);
    tick;
    m_dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00);
    push_exp("alu_fwd_from_3", 0, CK_FW, 1'b0, 9'b0_0000_0011, 16'd0);
    tick;

    // load-use: lw r8, then a reader of r8
    m_dec(1'b1, 1'b1, 5'd8, 1'b1, 5'd2, 5'd0, 2'b01);
    push_exp("lu_no_stall_yet", 0, CK_ST, 1'b0, 9'd0, 16'd0);
    tick;
    m_dec(1'b1, 1'b1, 5'd9, 1'b0, 5'd8, 5'd0, 2'b01);
    push_exp("lu_stall", 0, CK_ST | CK_CN, 1'b1, 9'd0, 16'd0);
    #0;
    n_total++;
    if (m_stall === 1'b1) n_pass++;
    else $display("FAIL lu_stall_direct: got stall=%0b, want 1", m_stall);
    tick;
    push_exp("lu_one_bubble", 0, CK_ALL, 1'b0, 9'd0, 16'd1);
    tick;
    m_dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00);
    push_exp("lu_fwd_from_3", 0, CK_ALL, 1'b0, 9'b0_0000_0011, 16'd1);
    tick;

    // priority and r0
    m_dec(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 2'b00);
    tick;
    m_dec(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 2'b00);
    tick;
    m_dec(1'b1, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0, 2'b11);
    tick;
    m_dec(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00);
    push_exp("prio_youngest_wins", 0, CK_FW, 1'b0, 9'b0_0000_0010, 16'd0);
    tick;
    m_dec(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 5'd3, 2'b11);
    tick;
    m_dec(1'b1, 1'b1, 5'd10, 1'b1, 5'd3, 5'd0, 2'b01);
    push_exp("r0_never_forwarded", 0, CK_FW, 1'b0, 9'b0_0000_1100, 16'd0);
    tick;

    // freeze with a load-use pending, then flush
    m_dec(1'b1, 1'b1, 5'd11, 1'b0, 5'd0, 5'd10, 2'b10);
    m_adv = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      push_exp("freeze_hold", 0, CK_ALL, 1'b1, 9'b0_0000_0010, 16'd1);
      tick;
    end
    m_flush = 1'b1;
    push_exp("flush_drops_stall", 0, CK_ALL, 1'b0, 9'b0_0000_0010, 16'd1);
    tick;
    m_flush = 1'b0;
    push_exp("flush_cleared_s1", 0, CK_ALL, 1'b0, 9'd0, 16'd1);
    tick;

    // reset in the middle of a stall
    m_adv = 1'b1;
    m_dec(1'b1, 1'b1, 5'd14, 1'b1, 5'd0, 5'd0, 2'b00);
    tick;
    m_dec(1'b1, 1'b1, 5'd15, 1'b0, 5'd14, 5'd0, 2'b01);
    push_exp("rst_pre_stall", 0, CK_ST | CK_CN, 1'b1, 9'd0, 16'd1);
    #5 rst_n = 1'b0;
    #1;
    push_exp("rst_async_clear", 0, CK_ALL, 1'b0, 9'd0, 16'd0);
    n_total++;
    if (m_cnt === 16'd0 && m_stall === 1'b0) n_pass++;
    else $display("FAIL rst_async_direct: got stall=%0b count=%0h, want 0/0", m_stall, m_cnt);
    -> chk_ev;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp("rst_no_partial", 0, CK_ALL, 1'b0, 9'd0, 16'd0);
    tick;
    m_dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00);

    // swept instance: two bubbles per load-use, forwarding from stages 2..5
    s_dec(1'b1, 1'b1, 5'd12, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000);
    push_exp("sw_idle", 1, CK_ST | CK_CN, 1'b0, 9'd0, 16'd0);
    tick;
    s_dec(1'b1, 1'b1, 5'd13, 1'b0, 5'd0, 5'd0, 5'd12, 3'b100);
    push_exp("sw_stall_load_s1", 1, CK_ST | CK_CN, 1'b1, 9'd0, 16'd0);
    tick;
    push_exp("sw_stall_load_s2", 1, CK_ST | CK_CN, 1'b1, 9'd0, 16'd1);
    tick;
    push_exp("sw_release", 1, CK_ST | CK_CN, 1'b0, 9'd0, 16'd2);
    n_total++;
    if (s_cnt === 16'd2) n_pass++;
    else $display("FAIL sw_two_bubbles_direct: got count=%0h, want 2", s_cnt);
    tick;
    s_dec(1'b1, 1'b1, 5'd20, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
    push_exp("sw_fwd_load_s4", 1, CK_ALL, 1'b0, {3'd4, 3'd0, 3'd0}, 16'd2);
    tick;
    s_dec(1'b1, 1'b1, 5'd21, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
    tick;
    s_dec(1'b1, 1'b1, 5'd22, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
    tick;
    s_dec(1'b1, 1'b1, 5'd23, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
    tick;
    s_dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd20, 5'd22, 5'd23, 3'b111);
    tick;
    s_dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd21, 5'd23, 5'd0, 3'b111);
    push_exp("sw_fwd_5_3_2", 1, CK_FW, 1'b0, {3'd2, 3'd3, 3'd5}, 16'd0);
    tick;
    s_dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
    push_exp("sw_fwd_5_3_r0", 1, CK_FW, 1'b0, {3'd0, 3'd3, 3'd5}, 16'd0);
    tick;

    // deep instance: drive the counter to saturation, then reset mid-stall
    t_rst_n = 1'b1;
    for (int unsigned c = 0; c <= 78644; c++) begin
      if (c == 7) push_exp("deep_fwd_from_7", 2, CK_ALL, 1'b1, 9'd7, sat_cnt(c));
      if ((c % 20000) == 3 || c >= 78641)
        push_exp("deep_count", 2, CK_ST | CK_CN, ((c % 6) != 0), 9'd0, sat_cnt(c));
      if (c != 78644) tick;
    end
    #5 t_rst_n = 1'b0;
    #1;
    push_exp("deep_rst_async_clear", 2, CK_ALL, 1'b0, 9'd0, 16'd0);
    -> chk_ev;

    repeat (2) @(posedge clk);
    while (q_nm.size() != 0) begin
      $display("FAIL %s: never compared, want stall=%0b count=%0h", q_nm[0], q_st[0], q_cn[0]);
      void'(q_nm.pop_front()); void'(q_inst.pop_front()); void'(q_mask.pop_front());
      void'(q_st.pop_front()); void'(q_fw.pop_front()); void'(q_cn.pop_front());
      n_total++;
    end
    if (n_pass != n_total || n_total < 12)
      $display("FAIL summary: %0d/%0d checks passed", n_pass, n_total);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
